// File: rtl/sample_feeder.sv
// sample_feeder: FIFO-buffered sample source that streams a gap-free run of
// N_ITER samples to the shift-accumulate core, zero-filling on underrun.
module sample_feeder #(
    parameter int DEPTH  = 16,
    parameter int N_ITER = 99
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    input  logic [7:0]               wr_data,
    output logic                     wr_ready,
    input  logic                     start,
    output logic                     en,
    output logic [7:0]               out_data,
    output logic                     busy,
    output logic                     done,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(N_ITER + 1);
    localparam logic [BW-1:0] LAST = BW'(N_ITER);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic            en_q, en_d;
    logic [7:0]      out_q, out_d;
    logic            done_q, done_d;
    logic            und_q, und_d;
    logic [LW-1:0]   level_q, level_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]      mem [DEPTH];
    logic            empty, load, push, pop;
    logic [7:0]      head;

    assign empty    = level_q == '0;
    assign head     = mem[rd_ptr_q];
    assign wr_ready = level_q < LW'(DEPTH);
    assign push     = wr_valid && wr_ready;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        done_d  = 1'b0;
        und_d   = und_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_RUN;
                beat_d  = BW'(1);
                load    = 1'b1;
                und_d   = empty;
            end
            S_RUN: if (beat_q < LAST) begin
                load   = 1'b1;
                beat_d = beat_q + BW'(1);
                und_d  = und_q || empty;
            end else begin
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        // A beat with an empty FIFO still drives en, but with a zero sample
        pop      = load && !empty;
        en_d     = load;
        out_d    = pop ? head : 8'h00;
        level_d  = level_q + LW'(push) - LW'(pop);
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            beat_q   <= '0;
            en_q     <= 1'b0;
            out_q    <= '0;
            done_q   <= 1'b0;
            und_q    <= 1'b0;
            level_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            en_q     <= en_d;
            out_q    <= out_d;
            done_q   <= done_d;
            und_q    <= und_d;
            level_q  <= level_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end

    assign en       = en_q;
    assign busy     = en_q;
    assign out_data = out_q;
    assign done     = done_q;
    assign underrun = und_q;
    assign level    = level_q;
endmodule
